// File: rtl/rf_op_sequencer_pkg.sv
// Shared constants and opcode encoding for the register-file micro-op sequencer.
package rf_op_sequencer_pkg;

  localparam int NUM_REGS = 8;
  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = $clog2(NUM_REGS);
  localparam int ZERO_REG = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_ADDI = 3'b110,
    OP_LI   = 3'b111
  } op_e;

endpackage

// File: rtl/rf_op_sequencer_if.sv
// Micro-op stream, result stream and register-file port bundle of the sequencer.
interface rf_op_sequencer_if
  import rf_op_sequencer_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic [DW-1:0] in_imm;
  logic          WEN;
  logic [AW-1:0] RW;
  logic [DW-1:0] busW;
  logic [AW-1:0] RX;
  logic [AW-1:0] RY;
  logic [DW-1:0] busX;
  logic [DW-1:0] busY;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_rd;
  logic [DW-1:0] out_data;

  // slave: the sequencer itself
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, busX, busY, out_ready,
    output in_ready, WEN, RW, busW, RX, RY, out_valid, out_rd, out_data
  );

  // master: the environment (micro-op source, register file, result sink)
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, busX, busY, out_ready,
    input  in_ready, WEN, RW, busW, RX, RY, out_valid, out_rd, out_data
  );
endinterface

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer E stage; arithmetic wraps mod 2^DW.
module rf_seq_alu
  import rf_op_sequencer_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  op_e           op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] result
);

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = ($signed(a) < $signed(b)) ? {{(DW-1){1'b0}}, 1'b1} : '0;
      OP_ADDI: result = a + imm;
      OP_LI:   result = imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Two-stage (E: read+compute, W: commit) micro-op sequencer driving an 8x8 register file.
// Define RFSEQ_FWD_EN to forward W results into E; otherwise dependent ops stall until commit.
module rf_op_sequencer
  import rf_op_sequencer_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input logic              Clk,
  input logic              Rst,
  rf_op_sequencer_if.slave bus
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic          e_valid_q, e_valid_d;
  op_e           e_op_q, e_op_d;
  logic [AW-1:0] e_rd_q, e_rd_d;
  logic [AW-1:0] e_rs1_q, e_rs1_d;
  logic [AW-1:0] e_rs2_q, e_rs2_d;
  logic [DW-1:0] e_imm_q, e_imm_d;
  logic          w_valid_q, w_valid_d;
  logic [AW-1:0] w_rd_q, w_rd_d;
  logic [DW-1:0] w_data_q, w_data_d;

  logic          fwd_a, fwd_b, hazard_stall;
  logic          w_adv, e_adv, in_ready;
  logic [DW-1:0] op_a, op_b, alu_res;

  always_comb begin
`ifdef RFSEQ_FWD_EN
    fwd_a        = w_valid_q && (w_rd_q == e_rs1_q) && (e_rs1_q != ZERO_ADDR);
    fwd_b        = w_valid_q && (w_rd_q == e_rs2_q) && (e_rs2_q != ZERO_ADDR);
    hazard_stall = 1'b0;
`else
    fwd_a        = 1'b0;
    fwd_b        = 1'b0;
    hazard_stall = w_valid_q && (w_rd_q != ZERO_ADDR) &&
                   ((w_rd_q == e_rs1_q) || (w_rd_q == e_rs2_q));
`endif
    // r0 reads as zero even if the register file were to return something else
    op_a = (e_rs1_q == ZERO_ADDR) ? '0 : (fwd_a ? w_data_q : bus.busX);
    op_b = (e_rs2_q == ZERO_ADDR) ? '0 : (fwd_b ? w_data_q : bus.busY);
  end

  rf_seq_alu #(.DW(DW)) u_alu (
    .op     (e_op_q),
    .a      (op_a),
    .b      (op_b),
    .imm    (e_imm_q),
    .result (alu_res)
  );

  always_comb begin
    w_adv    = !w_valid_q || bus.out_ready;
    e_adv    = e_valid_q && w_adv && !hazard_stall;
    in_ready = !e_valid_q || e_adv;

    e_valid_d = e_valid_q;
    e_op_d    = e_op_q;
    e_rd_d    = e_rd_q;
    e_rs1_d   = e_rs1_q;
    e_rs2_d   = e_rs2_q;
    e_imm_d   = e_imm_q;
    if (in_ready) begin
      e_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        e_op_d  = op_e'(bus.in_op);
        e_rd_d  = bus.in_rd;
        e_rs1_d = bus.in_rs1;
        e_rs2_d = bus.in_rs2;
        e_imm_d = bus.in_imm;
      end
    end

    w_valid_d = w_valid_q;
    w_rd_d    = w_rd_q;
    w_data_d  = w_data_q;
    if (e_adv) begin
      w_valid_d = 1'b1;
      w_rd_d    = e_rd_q;
      w_data_d  = alu_res;
    end else if (bus.out_ready) begin
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      e_valid_q <= 1'b0;
      e_op_q    <= OP_ADD;
      e_rd_q    <= '0;
      e_rs1_q   <= '0;
      e_rs2_q   <= '0;
      e_imm_q   <= '0;
      w_valid_q <= 1'b0;
      w_rd_q    <= '0;
      w_data_q  <= '0;
    end else begin
      e_valid_q <= e_valid_d;
      e_op_q    <= e_op_d;
      e_rd_q    <= e_rd_d;
      e_rs1_q   <= e_rs1_d;
      e_rs2_q   <= e_rs2_d;
      e_imm_q   <= e_imm_d;
      w_valid_q <= w_valid_d;
      w_rd_q    <= w_rd_d;
      w_data_q  <= w_data_d;
    end
  end

  // Gating with Rst keeps a reset edge from also writing the in-flight W result.
  assign bus.WEN       = w_valid_q & bus.out_ready & ~Rst;
  assign bus.RW        = w_rd_q;
  assign bus.busW      = w_data_q;
  assign bus.RX        = e_rs1_q;
  assign bus.RY        = e_rs2_q;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = w_valid_q;
  assign bus.out_rd    = w_rd_q;
  assign bus.out_data  = w_data_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench for rf_op_sequencer: register-file model, in-order architectural reference, directed + random ops.
module tb_rf_op_sequencer;

  typedef struct packed {
    logic [2:0] rd;
    logic [7:0] data;
  } exp_t;

`ifdef RFSEQ_FWD_EN
  localparam int DEP_GAP = 1;
`else
  localparam int DEP_GAP = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rf_clear = 1'b1;
  always #5 clk = ~clk;

  rf_op_sequencer_if #(.DW(8), .AW(3)) bus ();

  rf_op_sequencer #(.DW(8), .AW(3)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  // register file: r0 hardwired to zero, combinational reads, write on rising edge
  logic [7:0] rf [8];
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else if (bus.WEN === 1'b1 && bus.RW != 3'd0) begin
      rf[bus.RW] <= bus.busW;
    end
  end
  assign bus.busX = (bus.RX == 3'd0) ? 8'h00 : rf[bus.RX];
  assign bus.busY = (bus.RY == 3'd0) ? 8'h00 : rf[bus.RY];

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  bit         last_acc;
  bit         wen_r0_seen;
  exp_t       exp_q[$];
  int         commit_cyc[$];
  logic [7:0] commit_data[$];
  logic [7:0] ref_regs [8];
  logic [7:0] ref_committed [8];
  logic [7:0] rf_snap [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int sx(input logic [7:0] v);
    return (v >= 8'd128) ? int'(v) - 256 : int'(v);
  endfunction

  // Architectural meaning of each opcode, evaluated in program order.
  function automatic logic [7:0] ref_calc(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] imm);
    int r;
    case (op)
      3'd0: r = int'(a) + int'(b);
      3'd1: r = int'(a) - int'(b);
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = (sx(a) < sx(b)) ? 1 : 0;
      3'd6: r = int'(a) + int'(imm);
      default: r = int'(imm);
    endcase
    return 8'(r & 255);
  endfunction

  task automatic step();
    exp_t e;
    @(negedge clk);
    last_acc = 1'b0;
    if (!rst) begin
      chk("wen_vs_handshake", bus.WEN, bus.out_valid & bus.out_ready);
      if (bus.WEN === 1'b1 && bus.RW === 3'd0) wen_r0_seen = 1'b1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        chk("commit_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_rd", bus.out_rd, e.rd);
          chk("out_data", bus.out_data, e.data);
          if (e.rd != 3'd0) ref_committed[e.rd] = e.data;
          commit_cyc.push_back(cyc);
          commit_data.push_back(bus.out_data);
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        e.rd   = bus.in_rd;
        e.data = ref_calc(bus.in_op, ref_regs[bus.in_rs1], ref_regs[bus.in_rs2], bus.in_imm);
        exp_q.push_back(e);
        if (e.rd != 3'd0) ref_regs[e.rd] = e.data;
        last_acc = 1'b1;
      end
    end else begin
      chk("wen_in_reset", bus.WEN, 0);
      exp_q.delete();
      ref_regs = ref_committed;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm, input bit rnd_ready);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    for (int i = 0; i < 60; i++) begin
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 9) < 7);
      step();
      if (last_acc) break;
    end
    chk("issue_accepted", last_acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    logic [2:0] bp_rd  [3];
    logic [2:0] bp_op  [3];
    logic [2:0] bp_rs1 [3];
    logic [2:0] bp_rs2 [3];
    logic [7:0] bp_imm [3];
    int         idx;

    for (int i = 0; i < 8; i++) begin
      ref_regs[i]      = 8'h00;
      ref_committed[i] = 8'h00;
    end
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_rd     = 3'd0;
    bus.in_rs1    = 3'd0;
    bus.in_rs2    = 3'd0;
    bus.in_imm    = 8'h00;
    bus.out_ready = 1'b0;
    wen_r0_seen   = 1'b0;

    // reset
    step();
    rf_clear = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_wen", bus.WEN, 0);
    chk("rst_rx", bus.RX, 0);
    chk("rst_ry", bus.RY, 0);
    chk("rst_rw", bus.RW, 0);
    chk("rst_busw", bus.busW, 0);
    chk("rst_out_rd", bus.out_rd, 0);
    chk("rst_out_data", bus.out_data, 0);

    // LI r1,#5; LI r2,#3; ADD r3,r1,r2
    bus.out_ready = 1'b1;
    commit_cyc.delete();
    commit_data.delete();
    issue(3'd7, 3'd1, 3'd0, 3'd0, 8'd5, 1'b0);
    issue(3'd7, 3'd2, 3'd0, 3'd0, 8'd3, 1'b0);
    issue(3'd0, 3'd3, 3'd1, 3'd2, 8'd0, 1'b0);
    drain();
    chk("t1_commits", commit_cyc.size(), 3);
    if (commit_cyc.size() == 3) begin
      chk("t1_data0", commit_data[0], 8'd5);
      chk("t1_data1", commit_data[1], 8'd3);
      chk("t1_data2", commit_data[2], 8'd8);
      chk("t1_gap01", commit_cyc[1] - commit_cyc[0], 1);
      chk("t1_gap12", commit_cyc[2] - commit_cyc[1], DEP_GAP);
    end
    chk("t1_rf_r3", rf[3], 8'd8);

    // SUB r4,r2,r1; SLT r5,r4,r1; ADDI r6,r1,#0xFF
    issue(3'd1, 3'd4, 3'd2, 3'd1, 8'd0, 1'b0);
    chk("t2_rx", bus.RX, 2);
    chk("t2_ry", bus.RY, 1);
    issue(3'd5, 3'd5, 3'd4, 3'd1, 8'd0, 1'b0);
    issue(3'd6, 3'd6, 3'd1, 3'd0, 8'hFF, 1'b0);
    drain();
    chk("t2_rf_r4", rf[4], 8'hFE);
    chk("t2_rf_r5", rf[5], 8'h01);
    chk("t2_rf_r6", rf[6], 8'h04);

    // back-to-back dependency
    commit_cyc.delete();
    commit_data.delete();
    issue(3'd7, 3'd1, 3'd0, 3'd0, 8'd7, 1'b0);
    issue(3'd0, 3'd2, 3'd1, 3'd1, 8'd0, 1'b0);
    drain();
    chk("t3_commits", commit_cyc.size(), 2);
    if (commit_cyc.size() == 2) chk("t3_gap", commit_cyc[1] - commit_cyc[0], DEP_GAP);
    chk("t3_rf_r2", rf[2], 8'd14);

    // writes to r0 reach the port but never the operands
    wen_r0_seen = 1'b0;
    issue(3'd7, 3'd0, 3'd0, 3'd0, 8'd9, 1'b0);
    issue(3'd0, 3'd1, 3'd0, 3'd0, 8'd0, 1'b0);
    drain();
    chk("t4_wen_r0", wen_r0_seen, 1);
    chk("t4_rf_r1", rf[1], 8'd0);
    chk("t4_rf_r0", rf[0], 8'd0);

    // backpressure: 3 ops offered while out_ready is low for 4 cycles
    bp_op  = '{3'd7, 3'd7, 3'd0};
    bp_rd  = '{3'd1, 3'd2, 3'd3};
    bp_rs1 = '{3'd0, 3'd0, 3'd1};
    bp_rs2 = '{3'd0, 3'd0, 3'd2};
    bp_imm = '{8'h11, 8'h22, 8'h00};
    commit_cyc.delete();
    commit_data.delete();
    bus.out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = bp_op[idx];
      bus.in_rd    = bp_rd[idx];
      bus.in_rs1   = bp_rs1[idx];
      bus.in_rs2   = bp_rs2[idx];
      bus.in_imm   = bp_imm[idx];
      step();
      if (last_acc && idx < 2) idx++;
      if (i >= 1) begin
        chk("t5_hold_valid", bus.out_valid, 1);
        chk("t5_hold_data", bus.out_data, 8'h11);
      end
    end
    chk("t5_accepts", idx, 2);
    chk("t5_in_ready_low", bus.in_ready, 0);
    chk("t5_no_commit", commit_cyc.size(), 0);
    bus.out_ready = 1'b1;
    issue(bp_op[2], bp_rd[2], bp_rs1[2], bp_rs2[2], bp_imm[2], 1'b0);
    drain();
    chk("t5_commits", commit_data.size(), 3);
    if (commit_data.size() == 3) begin
      chk("t5_order0", commit_data[0], 8'h11);
      chk("t5_order1", commit_data[1], 8'h22);
      chk("t5_order2", commit_data[2], 8'h33);
    end

    // reset with ops in both E and W
    rf_snap = rf;
    bus.out_ready = 1'b0;
    issue(3'd7, 3'd7, 3'd0, 3'd0, 8'hAA, 1'b0);
    issue(3'd7, 3'd6, 3'd0, 3'd0, 8'h55, 1'b0);
    chk("t6_w_full", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_in_ready", bus.in_ready, 1);
    chk("t6_out_data", bus.out_data, 0);
    chk("t6_rw", bus.RW, 0);
    step();
    chk("t6_still_idle", bus.out_valid, 0);
    chk("t6_rf_r7", rf[7], rf_snap[7]);
    chk("t6_rf_r6", rf[6], rf_snap[6]);

    // random ops under random backpressure
    for (int n = 0; n < 200; n++) begin
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'b1);
    end
    drain();
    for (int i = 0; i < 8; i++) chk("final_rf", rf[i], ref_committed[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
